// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM that sequences the shared datapath
// through fetch/decode/execute. It drives every datapath select, enable and
// ALU mode, and bounds each memory wait with a small cycle counter.
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | read instruction at PC, PC+4; IR/PC load when memory ready
// DECODE | latch opcode, precompute branch target into ALUOut
// MEMADR | compute load/store address rs + imm
// MEMRD  | data read at ALUOut, wait for memory ready
// MEMWB  | write MDR into rt
// MEMWR  | data write at ALUOut, wait for memory ready
// EXEC   | R-type ALU operation on rs, rt
// RWB    | write ALUOut into rd
// BRANCH | compare rs/rt, load PC from ALUOut when taken
// IEXEC  | immediate ALU operation on rs, extended imm
// IWB    | write ALUOut into rt
// JUMP   | load PC with jump target
module multicycle_control #(
  parameter int TIMEOUT = 15
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       ExtOp,
  output logic       MemFault,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [5:0] opreg;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       pcen_raw, irwrite_raw, memfault_raw, illegal_raw;
  logic       mem_wait, timeout;

  assign timeout = (wait_cnt == WAIT_LAST) && !MemReady;

  // State, latched opcode and memory wait counter
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= FETCH;
      opreg    <= 6'd0;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == DECODE) opreg <= Opcode;
    end
  end

  // Next state and Moore outputs per state
  always_comb begin
    state_nxt    = state;
    pcen_raw     = 1'b0;
    irwrite_raw  = 1'b0;
    memfault_raw = 1'b0;
    illegal_raw  = 1'b0;
    mem_wait     = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    PCSource     = 2'b00;
    ExtOp        = 1'b1;
    case (state)
      FETCH: begin
        MemRead     = 1'b1;
        ALUSrcB     = 2'b01;
        pcen_raw    = MemReady;
        irwrite_raw = MemReady;
        mem_wait    = 1'b1;
        if (MemReady)     state_nxt = DECODE;
        else if (timeout) memfault_raw = 1'b1;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:                        state_nxt = MEMADR;
          OP_R:                                state_nxt = EXEC;
          OP_BEQ, OP_BNE:                      state_nxt = BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:   state_nxt = IEXEC;
          OP_J:                                state_nxt = JUMP;
          default: begin
            state_nxt   = FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        state_nxt = (opreg == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        IorD     = 1'b1;
        MemRead  = 1'b1;
        mem_wait = 1'b1;
        if (MemReady) state_nxt = MEMWB;
        else if (timeout) begin
          memfault_raw = 1'b1;
          state_nxt    = FETCH;
        end
      end
      MEMWB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        state_nxt = FETCH;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        mem_wait = 1'b1;
        if (MemReady) state_nxt = FETCH;
        else if (timeout) begin
          memfault_raw = 1'b1;
          state_nxt    = FETCH;
        end
      end
      EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        state_nxt = RWB;
      end
      RWB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        state_nxt = FETCH;
      end
      BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b01;
        PCSource  = 2'b01;
        pcen_raw  = ((opreg == OP_BEQ) && Zero) || ((opreg == OP_BNE) && !Zero);
        state_nxt = FETCH;
      end
      IEXEC: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUOp     = 2'b11;
        ExtOp     = !((opreg == OP_ANDI) || (opreg == OP_ORI));
        state_nxt = IWB;
      end
      IWB: begin
        RegWrite  = 1'b1;
        state_nxt = FETCH;
      end
      JUMP: begin
        PCSource  = 2'b10;
        pcen_raw  = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Wait counter restarts on any state change and on a timeout retry
  always_comb begin
    wait_cnt_nxt = 4'd0;
    if ((state_nxt == state) && !memfault_raw && mem_wait && !MemReady)
      wait_cnt_nxt = wait_cnt + 4'd1;
  end

  // Strobes that could corrupt PC/IR or raise events are held off during reset
  assign PCEn      = pcen_raw     & Rst_n;
  assign IRWrite   = irwrite_raw  & Rst_n;
  assign MemFault  = memfault_raw & Rst_n;
  assign IllegalOp = illegal_raw  & Rst_n;
  assign State     = state;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS control unit: a Moore FSM that sequences the shared datapath (PC, memory port, IR, register file, ALU, immediate extender) through fetch/decode/execute steps. It sits beside the datapath and drives every mux select, write enable and ALU mode. It also configures the immediate extender: sign extension for arithmetic, memory and branch instructions, zero extension for logical immediates. Memory accesses use a ready handshake with a bounded wait.

## Interface
Parameters:
- TIMEOUT, 15, max cycles spent waiting for MemReady in one memory state (4-bit wait counter, 1..15)

Ports:
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Opcode  in  6  instruction[31:26] from IR
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes current access this cycle
- PCEn  out  1  PC load enable
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- RegDst  out  1  write register: 0=rt, 1=rd
- MemtoReg  out  1  write data: 0=ALUOut, 1=MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrcB  out  2  00=rt, 01=4, 10=Imm32, 11=Imm32<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct, 11=immediate (opcode-decoded)
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
- ExtOp  out  1  1=sign extend, 0=zero extend
- MemFault  out  1  one-cycle pulse on MemReady timeout
- IllegalOp  out  1  one-cycle pulse on unsupported opcode
- State  out  4  current state (debug)

## Operation
- States (encoding): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11; codes 12–15 → FETCH next cycle.
- All outputs default 0, ExtOp defaults 1; only listed values differ.
- FETCH: MemRead=1, ALUSrcB=01, IRWrite=PCEn=MemReady. MemReady → DECODE, else stay.
- DECODE: ALUSrcB=11; latch Opcode into internal OpReg. Next: LW/SW(100011/101011)→MEMADR; R(000000)→EXEC; BEQ/BNE(000100/000101)→BRANCH; ADDI/SLTI/ANDI/ORI(001000/001010/001100/001101)→IEXEC; J(000010)→JUMP; other→FETCH with IllegalOp=1 for that cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10; LW→MEMRD, SW→MEMWR.
- MEMRD: IorD=1, MemRead=1; MemReady→MEMWB. MEMWB: MemtoReg=1, RegWrite=1 →FETCH.
- MEMWR: IorD=1, MemWrite=1; MemReady→FETCH.
- EXEC: ALUSrcA=1, ALUOp=10 →RWB. RWB: RegDst=1, RegWrite=1 →FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01, PCEn=(OpReg==BEQ & Zero)|(OpReg==BNE & !Zero) →FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11, ExtOp=0 if OpReg is ANDI/ORI →IWB. IWB: RegWrite=1 →FETCH.
- JUMP: PCSource=10, PCEn=1 →FETCH.
- Wait counter: cleared on every state change; increments each cycle in FETCH/MEMRD/MEMWR with MemReady=0. When it equals TIMEOUT−1 and MemReady=0: MemFault=1 that cycle, next state FETCH (counter cleared; FETCH retries). MemReady in the same cycle wins over timeout.

## Timing
- Outputs combinational from State, OpReg, Zero, MemReady; State, OpReg, counter registered on Clk rising.
- Reset (Rst_n=0, async): State=FETCH, OpReg=0, counter=0; PCEn, IRWrite, MemFault, IllegalOp forced 0 while Rst_n=0; others take FETCH values (MemRead=1, ALUSrcB=01, ExtOp=1). Reset mid-instruction abandons it; no RegWrite/MemWrite after reset assertion.
- Latency with zero-wait memory (MemReady=1): R 4, LW 5, SW 4, BEQ/BNE 3, I-type 4, J 3, illegal 2 cycles. Each MemReady-low cycle adds one.
- Opcode only sampled in DECODE; later changes ignored.

## Test plan
- Reset with MemReady=1 → State=0, PCEn=IRWrite=0; release → first edge loads IR/PC, State=1.
- LW (100011), MemReady always 1 → states 0,1,2,3,4,0; RegWrite=1, MemtoReg=1 only in state 4; ExtOp=1 throughout.
- ORI (001101) → states 0,1,9,10,0; ExtOp=0 in state 9, ALUOp=11; ADDI same path with ExtOp=1.
- BEQ Zero=1 → PCEn=1, PCSource=01 in state 8; BNE Zero=1 → PCEn=0; 3 cycles each.
- SW with MemReady low 3 cycles in MEMWR → MemWrite held 4 cycles, then FETCH; MemReady never high, TIMEOUT=15 → MemFault single pulse on 15th cycle, State=0 next.
- Opcode 111111 → IllegalOp pulse in DECODE, back to FETCH; Rst_n low during state 6 → State=0 immediately, RegWrite never asserted.
